cpu_control: RTL

CPU_CONTROL -- requirements
Module: cpu_control

---
 rtl/cpu_control.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_control.sv
// cpu_control: multi-cycle control FSM (fetch/decode/execute/memory/writeback)
// with a memory-wait watchdog, a sticky trap state and a retired-instruction
// counter.
module cpu_control #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [3:0]  inst_type,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_fetch,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        illegal,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_TRAP      = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // Decode-stage code for an instruction it could not classify.
    localparam logic [3:0] TYPE_INVALID = 4'hF;

    localparam int              WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    // Last tolerated wait value: one more unready cycle completes the timeout.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       retired_q, retired_d;
    logic              retire;

    // Raw strobes before reset gating.
    logic       mem_req_c, mem_we_c, mem_is_fetch_c, ir_we_c, pc_we_c, rf_we_c;
    logic       alu_a_c, alu_b_c, illegal_c;
    logic [1:0] pc_sel_c, wb_sel_c;

    // Next-state, strobe and counter logic for the current state and latched opcode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d        = state_q;
        op_d           = op_q;
        retire         = 1'b0;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_is_fetch_c = 1'b0;
        ir_we_c        = 1'b0;
        pc_we_c        = 1'b0;
        rf_we_c        = 1'b0;
        alu_a_c        = 1'b0;
        alu_b_c        = 1'b0;
        illegal_c      = 1'b0;
        pc_sel_c       = 2'd0;
        wb_sel_c       = 2'd0;

        // ALU operand selects follow the latched opcode once it is known.
        if (state_q == S_EXECUTE || state_q == S_MEMORY || state_q == S_WRITEBACK) begin
            alu_a_c = (op_q == OP_AUIPC);
            alu_b_c = (op_q == OP_IMM)   || (op_q == OP_LOAD) || (op_q == OP_STORE) ||
                      (op_q == OP_AUIPC) || (op_q == OP_JALR);
        end

        case (state_q)
            S_FETCH: begin
                mem_req_c      = 1'b1;
                mem_is_fetch_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    op_d    = opcode;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                state_d = (inst_type == TYPE_INVALID) ? S_TRAP : S_EXECUTE;
            end
            S_EXECUTE: begin
                case (op_q)
                    OP_LOAD, OP_STORE: state_d = S_MEMORY;
                    OP_BRANCH: begin
                        pc_we_c  = 1'b1;
                        pc_sel_c = branch_taken ? 2'd1 : 2'd0;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_FENCE, OP_SYSTEM: begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                mem_req_c = 1'b1;
                mem_we_c  = (op_q == OP_STORE);
                if (mem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                if (op_q == OP_LUI)                          wb_sel_c = 2'd3;
                else if (op_q == OP_JAL || op_q == OP_JALR)  wb_sel_c = 2'd2;
                else if (op_q == OP_LOAD)                    wb_sel_c = 2'd1;
                if (op_q == OP_JAL)                          pc_sel_c = 2'd1;
                else if (op_q == OP_JALR)                    pc_sel_c = 2'd2;
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Wait counter: consecutive unanswered requests, restarted by any state change.
        if (state_d != state_q)
            wait_d = '0;
        else if (mem_req_c && !mem_ready)
            wait_d = wait_q + WAIT_W'(1);
        else
            wait_d = wait_q;

        retired_d = retired_q + 32'(retire);
    end

    // State, latched opcode, wait counter and retire counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    // Strobes are forced low while reset is held; FETCH would otherwise request memory.
    assign mem_req      = mem_req_c      & ~rst;
    assign mem_we       = mem_we_c       & ~rst;
    assign mem_is_fetch = mem_is_fetch_c & ~rst;
    assign ir_we        = ir_we_c        & ~rst;
    assign pc_we        = pc_we_c        & ~rst;
    assign rf_we        = rf_we_c        & ~rst;
    assign alu_a_sel    = alu_a_c        & ~rst;
    assign alu_b_sel    = alu_b_c        & ~rst;
    assign illegal      = illegal_c      & ~rst;
    assign pc_sel       = pc_sel_c       & {2{~rst}};
    assign wb_sel       = wb_sel_c       & {2{~rst}};
    assign state        = state_q;
    assign retired      = retired_q;

endmodule
